// File: rtl/game_controller.sv
// Game sequencing FSM: turns frame pulses into entity ticks and tracks lives,
// BCD score and level across the IDLE / JOGANDO / PAUSA / RESPAWN / FIM states.
module game_controller #(
    parameter int VIDAS_INICIAIS = 3,
    parameter int TICK_DIV       = 1,
    parameter int RESPAWN_FRAMES = 60,
    parameter int FIM_FRAMES     = 120,
    parameter int MAX_NIVEL      = 15
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        start_btn,
    input  logic        pausa,
    input  logic        hit_player,
    input  logic        hit_enemy,
    input  logic        enemies_dead,
    output logic [2:0]  estado,
    output logic        tick_update,
    output logic        clear_entities,
    output logic [1:0]  vidas,
    output logic [15:0] pontos,
    output logic [3:0]  nivel,
    output logic        perdeu
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        JOGANDO = 3'd1,
        PAUSA   = 3'd2,
        RESPAWN = 3'd3,
        FIM     = 3'd4
    } state_t;

    localparam logic [1:0] VIDAS_INIT = 2'(VIDAS_INICIAIS);
    localparam logic [3:0] DIV_LAST   = 4'(TICK_DIV - 1);
    localparam logic [7:0] RESP_LAST  = 8'(RESPAWN_FRAMES - 1);
    localparam logic [7:0] FIM_SAT    = 8'(FIM_FRAMES);
    localparam logic [3:0] NIVEL_MAX  = 4'(MAX_NIVEL);

    state_t      state_q, state_d;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  resp_cnt_q, resp_cnt_d;
    logic [7:0]  fim_cnt_q, fim_cnt_d;
    logic [1:0]  ed_block_q, ed_block_d;
    logic        clear_req_q, clear_req_d;
    logic        tick_d, clear_d, perdeu_d, do_start;
    logic [1:0]  vidas_d;
    logic [15:0] pontos_d;
    logic [3:0]  nivel_d;

    // Decimal increment with per-digit carry; 9999 is the ceiling.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q        <= IDLE;
            frame_cnt_q    <= 4'd0;
            resp_cnt_q     <= 8'd0;
            fim_cnt_q      <= 8'd0;
            ed_block_q     <= 2'd0;
            clear_req_q    <= 1'b0;
            tick_update    <= 1'b0;
            clear_entities <= 1'b0;
            vidas          <= VIDAS_INIT;
            pontos         <= 16'h0000;
            nivel          <= 4'd0;
            perdeu         <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            resp_cnt_q     <= resp_cnt_d;
            fim_cnt_q      <= fim_cnt_d;
            ed_block_q     <= ed_block_d;
            clear_req_q    <= clear_req_d;
            tick_update    <= tick_d;
            clear_entities <= clear_d;
            vidas          <= vidas_d;
            pontos         <= pontos_d;
            nivel          <= nivel_d;
            perdeu         <= perdeu_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        resp_cnt_d  = resp_cnt_q;
        fim_cnt_d   = fim_cnt_q;
        ed_block_d  = (ed_block_q != 2'd0) ? ed_block_q - 2'd1 : 2'd0;
        clear_req_d = 1'b0;
        tick_d      = 1'b0;
        vidas_d     = vidas;
        pontos_d    = pontos;
        nivel_d     = nivel;
        do_start    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_btn) do_start = 1'b1;
            end
            JOGANDO: begin
                if (hit_enemy) pontos_d = bcd_inc(pontos);
                // Losing a life pre-empts level advance, pause and ticking this cycle.
                if (hit_player) begin
                    if (vidas <= 2'd1) begin
                        vidas_d   = 2'd0;
                        state_d   = FIM;
                        fim_cnt_d = 8'd0;
                    end else begin
                        vidas_d    = vidas - 2'd1;
                        state_d    = RESPAWN;
                        resp_cnt_d = 8'd0;
                    end
                end else begin
                    if (enemies_dead && ed_block_q == 2'd0) begin
                        nivel_d     = (nivel == NIVEL_MAX) ? nivel : nivel + 4'd1;
                        clear_req_d = 1'b1;
                        ed_block_d  = 2'd2;
                    end
                    if (pausa) begin
                        state_d = PAUSA;
                    end else if (frame_start) begin
                        if (frame_cnt_q == DIV_LAST) begin
                            tick_d      = 1'b1;
                            frame_cnt_d = 4'd0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 4'd1;
                        end
                    end
                end
            end
            PAUSA: begin
                if (!pausa) state_d = JOGANDO;
            end
            RESPAWN: begin
                if (frame_start) begin
                    if (resp_cnt_q >= RESP_LAST) begin
                        state_d     = JOGANDO;
                        clear_req_d = 1'b1;
                        resp_cnt_d  = 8'd0;
                    end else begin
                        resp_cnt_d = resp_cnt_q + 8'd1;
                    end
                end
            end
            FIM: begin
                if (frame_start && fim_cnt_q < FIM_SAT) fim_cnt_d = fim_cnt_q + 8'd1;
                if (start_btn && fim_cnt_q >= FIM_SAT) do_start = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (do_start) begin
            state_d     = JOGANDO;
            vidas_d     = VIDAS_INIT;
            pontos_d    = 16'h0000;
            nivel_d     = 4'd0;
            frame_cnt_d = 4'd0;
            resp_cnt_d  = 8'd0;
            fim_cnt_d   = 8'd0;
            ed_block_d  = 2'd0;
            clear_req_d = 1'b1;
        end

        // Reload requests are delayed one register so entities see them after the state change.
        clear_d  = clear_req_q;
        perdeu_d = (state_d == FIM);
    end

    assign estado = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: directed stimulus pushes expected pulses and
// status snapshots; a negedge monitor pops and compares them.
module tb_game_controller;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_JOG  = 3'd1;
    localparam logic [2:0] S_PAU  = 3'd2;
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_FIM  = 3'd4;
    localparam logic [1:0] EV_TICK  = 2'b10;
    localparam logic [1:0] EV_CLEAR = 2'b01;

    logic        clk;
    logic        reset, frame_start, start_btn, pausa, hit_player, hit_enemy, enemies_dead;
    logic [2:0]  estado;
    logic        tick_update, clear_entities, perdeu;
    logic [1:0]  vidas;
    logic [15:0] pontos;
    logic [3:0]  nivel;

    game_controller #(
        .VIDAS_INICIAIS(3),
        .TICK_DIV(2),
        .RESPAWN_FRAMES(60),
        .FIM_FRAMES(120),
        .MAX_NIVEL(15)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .frame_start(frame_start),
        .start_btn(start_btn),
        .pausa(pausa),
        .hit_player(hit_player),
        .hit_enemy(hit_enemy),
        .enemies_dead(enemies_dead),
        .estado(estado),
        .tick_update(tick_update),
        .clear_entities(clear_entities),
        .vidas(vidas),
        .pontos(pontos),
        .nivel(nivel),
        .perdeu(perdeu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] kind;
        logic [2:0] estado;
        logic [1:0] vidas;
        logic [3:0] nivel;
    } ev_t;

    typedef struct {
        logic [2:0]  estado;
        logic [1:0]  vidas;
        logic [15:0] pontos;
        logic [3:0]  nivel;
        logic        perdeu;
    } st_t;

    ev_t   ev_q[$];
    st_t   st_q[$];
    string name_q[$];
    ev_t   ev_cur;
    st_t   st_cur;
    string name_cur;
    logic  chk_req;
    logic  prev_tick;
    int    tests_run;
    int    fails;
    int    tick_seen;
    int    tick_base;

    logic [2:0] m_state;
    logic [1:0] m_vidas;
    logic [3:0] m_nivel;
    int         m_div;
    int         m_resp;

    // Monitor: every tick/clear pulse must match the next expected event.
    always @(negedge clk) begin
        if (tick_update === 1'b1) begin
            tick_seen++;
            tests_run++;
            if (prev_tick !== 1'b0) begin
                fails++;
                $display("[TB] FAIL tick_width: tick_update high two cycles in a row, required one");
            end
        end
        prev_tick = tick_update;
        if (tick_update === 1'b1 || clear_entities === 1'b1) begin
            tests_run++;
            if (ev_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_pulse: got tick=%0b clear=%0b, required no pulse",
                         tick_update, clear_entities);
            end else begin
                ev_cur = ev_q.pop_front();
                if ({tick_update, clear_entities} !== ev_cur.kind || estado !== ev_cur.estado ||
                    vidas !== ev_cur.vidas || nivel !== ev_cur.nivel) begin
                    fails++;
                    $display("[TB] FAIL pulse: got tc=%b estado=%0d vidas=%0d nivel=%0d, required tc=%b estado=%0d vidas=%0d nivel=%0d",
                             {tick_update, clear_entities}, estado, vidas, nivel,
                             ev_cur.kind, ev_cur.estado, ev_cur.vidas, ev_cur.nivel);
                end
            end
        end
        if (chk_req === 1'b1 && st_q.size() != 0) begin
            st_cur   = st_q.pop_front();
            name_cur = name_q.pop_front();
            tests_run++;
            if (estado !== st_cur.estado || vidas !== st_cur.vidas || pontos !== st_cur.pontos ||
                nivel !== st_cur.nivel || perdeu !== st_cur.perdeu) begin
                fails++;
                $display("[TB] FAIL %s: got estado=%0d vidas=%0d pontos=%h nivel=%0d perdeu=%0b, required estado=%0d vidas=%0d pontos=%h nivel=%0d perdeu=%0b",
                         name_cur, estado, vidas, pontos, nivel, perdeu,
                         st_cur.estado, st_cur.vidas, st_cur.pontos, st_cur.nivel, st_cur.perdeu);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fs, input logic sb, input logic hp,
                                 input logic he, input logic ed);
        frame_start  = fs;
        start_btn    = sb;
        hit_player   = hp;
        hit_enemy    = he;
        enemies_dead = ed;
        cyc();
        frame_start  = 1'b0;
        start_btn    = 1'b0;
        hit_player   = 1'b0;
        hit_enemy    = 1'b0;
        enemies_dead = 1'b0;
        cyc();
    endtask

    task automatic checkOutput(input string name, input logic [2:0] e_est, input logic [1:0] e_vid,
                               input logic [15:0] e_pts, input logic [3:0] e_niv, input logic e_per);
        st_t s;
        s.estado = e_est;
        s.vidas  = e_vid;
        s.pontos = e_pts;
        s.nivel  = e_niv;
        s.perdeu = e_per;
        st_q.push_back(s);
        name_q.push_back(name);
        chk_req = 1'b1;
        cyc();
        chk_req = 1'b0;
    endtask

    task automatic push_event(input logic [1:0] kind, input logic [2:0] est,
                              input logic [1:0] vid, input logic [3:0] niv);
        ev_t e;
        e.kind   = kind;
        e.estado = est;
        e.vidas  = vid;
        e.nivel  = niv;
        ev_q.push_back(e);
    endtask

    task automatic frame();
        if (m_state == S_JOG) begin
            if (m_div == 1) begin
                push_event(EV_TICK, S_JOG, m_vidas, m_nivel);
                m_div = 0;
            end else begin
                m_div = 1;
            end
        end else if (m_state == S_RESP) begin
            if (m_resp == 59) begin
                m_state = S_JOG;
                m_resp  = 0;
                push_event(EV_CLEAR, S_JOG, m_vidas, m_nivel);
            end else begin
                m_resp++;
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic do_start();
        m_state = S_JOG;
        m_vidas = 2'd3;
        m_nivel = 4'd0;
        m_div   = 0;
        push_event(EV_CLEAR, S_JOG, 2'd3, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lose_life();
        m_vidas = m_vidas - 2'd1;
        m_state = S_RESP;
        m_resp  = 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic enemy_hits(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        tests_run = 0;
        fails = 0;
        tick_seen = 0;
        prev_tick = 1'b0;
        chk_req = 1'b0;
        m_state = S_IDLE;
        m_vidas = 2'd3;
        m_nivel = 4'd0;
        m_div = 0;
        m_resp = 0;
        reset = 1'b1;
        frame_start = 1'b0;
        start_btn = 1'b0;
        pausa = 1'b0;
        hit_player = 1'b0;
        hit_enemy = 1'b0;
        enemies_dead = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        checkOutput("reset_idle", S_IDLE, 2'd3, 16'h0000, 4'd0, 1'b0);
        frames(2);
        checkOutput("idle_no_ticks", S_IDLE, 2'd3, 16'h0000, 4'd0, 1'b0);

        $display("[TB] start and tick division");
        do_start();
        checkOutput("start", S_JOG, 2'd3, 16'h0000, 4'd0, 1'b0);
        tick_base = tick_seen;
        frames(6);
        tests_run++;
        if (tick_seen - tick_base != 3) begin
            fails++;
            $display("[TB] FAIL tick_count: got %0d ticks, required 3", tick_seen - tick_base);
        end

        $display("[TB] pause");
        pausa = 1'b1;
        cyc();
        m_state = S_PAU;
        checkOutput("pause_enter", S_PAU, 2'd3, 16'h0000, 4'd0, 1'b0);
        frames(10);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("pause_hit_ignored", S_PAU, 2'd3, 16'h0000, 4'd0, 1'b0);
        pausa = 1'b0;
        cyc();
        m_state = S_JOG;
        checkOutput("pause_release", S_JOG, 2'd3, 16'h0000, 4'd0, 1'b0);
        frames(2);

        $display("[TB] respawn");
        lose_life();
        checkOutput("respawn_enter", S_RESP, 2'd2, 16'h0000, 4'd0, 1'b0);
        frames(59);
        checkOutput("respawn_frame59", S_RESP, 2'd2, 16'h0000, 4'd0, 1'b0);
        frames(1);
        checkOutput("respawn_exit", S_JOG, 2'd2, 16'h0000, 4'd0, 1'b0);
        enemy_hits(42);
        checkOutput("score_42", S_JOG, 2'd2, 16'h0042, 4'd0, 1'b0);
        lose_life();
        frames(60);
        checkOutput("last_life", S_JOG, 2'd1, 16'h0042, 4'd0, 1'b0);

        $display("[TB] reset mid-game");
        reset = 1'b1;
        cyc();
        checkOutput("reset_midgame", S_IDLE, 2'd3, 16'h0000, 4'd0, 1'b0);
        reset = 1'b0;
        m_state = S_IDLE;
        m_vidas = 2'd3;
        m_nivel = 4'd0;

        $display("[TB] score carry and level");
        do_start();
        enemy_hits(99);
        checkOutput("score_99", S_JOG, 2'd3, 16'h0099, 4'd0, 1'b0);
        enemy_hits(1);
        checkOutput("score_carry", S_JOG, 2'd3, 16'h0100, 4'd0, 1'b0);
        push_event(EV_CLEAR, S_JOG, 2'd3, 4'd1);
        push_event(EV_CLEAR, S_JOG, 2'd3, 4'd2);
        m_nivel = 4'd2;
        enemies_dead = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        enemies_dead = 1'b0;
        cyc();
        cyc();
        checkOutput("level_hold", S_JOG, 2'd3, 16'h0100, 4'd2, 1'b0);

        $display("[TB] game over");
        lose_life();
        frames(60);
        lose_life();
        frames(60);
        checkOutput("one_life", S_JOG, 2'd1, 16'h0100, 4'd2, 1'b0);
        m_vidas = 2'd0;
        m_state = S_FIM;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("fim_enter", S_FIM, 2'd0, 16'h0101, 4'd2, 1'b1);
        frames(50);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("fim_start_50", S_FIM, 2'd0, 16'h0101, 4'd2, 1'b1);
        frames(69);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("fim_start_119", S_FIM, 2'd0, 16'h0101, 4'd2, 1'b1);
        frames(2);
        do_start();
        checkOutput("fim_restart", S_JOG, 2'd3, 16'h0000, 4'd0, 1'b0);

        $display("[TB] level and score saturation");
        for (int i = 0; i < 16; i++) begin
            m_nivel = (m_nivel == 4'd15) ? 4'd15 : m_nivel + 4'd1;
            push_event(EV_CLEAR, S_JOG, 2'd3, m_nivel);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            cyc();
        end
        checkOutput("level_sat", S_JOG, 2'd3, 16'h0000, 4'd15, 1'b0);
        enemy_hits(9999);
        checkOutput("score_9999", S_JOG, 2'd3, 16'h9999, 4'd15, 1'b0);
        enemy_hits(1);
        checkOutput("score_sat", S_JOG, 2'd3, 16'h9999, 4'd15, 1'b0);

        for (int i = 0; i < 4; i++) cyc();
        tests_run++;
        if (ev_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL pending_events: got %0d expected pulses never seen, required 0",
                     ev_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
